// File: rtl/codec_audio_pkg.sv
// codec_audio_pkg
// Shared constants and types for the codec DAC serializer.
//   SAMPLE_W   : width of one mono audio sample
//   SLOT_W     : bit clocks per left/right slot
//   FRAME_BITS : bit clocks per full left+right frame
//   CNT_W      : width of the frame bit counter
//   DIV_W      : width of the bit-clock divider counter (BCLK_DIV <= 255)
//   codec_state_t : serializer run state (IDLE / RUN)
package codec_audio_pkg;

    localparam int SAMPLE_W   = 20;
    localparam int SLOT_W     = 32;
    localparam int FRAME_BITS = 64;
    localparam int CNT_W      = $clog2(FRAME_BITS);
    localparam int DIV_W      = 8;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } codec_state_t;

endpackage

// File: rtl/codec_bclk_gen.sv
// codec_bclk_gen
// Divides clk down to the codec bit clock and flags its edges.
//   clk      : system clock
//   reset_n  : asynchronous active-low reset
//   run      : 1 = divider counts; 0 = divider cleared and bclk held low
//   bclk     : registered bit clock, half-period of BCLK_DIV clk cycles
//   rise_stb : high in the clk cycle whose closing edge drives bclk 0->1
//   fall_stb : high in the clk cycle whose closing edge drives bclk 1->0
// The strobes are combinational look-ahead so the consumer can update its
// own registers on exactly the same edge that moves bclk.
module codec_bclk_gen
    import codec_audio_pkg::*;
#(
    parameter int BCLK_DIV = 4
)
(
    input  logic clk,
    input  logic reset_n,
    input  logic run,
    output logic bclk,
    output logic rise_stb,
    output logic fall_stb
);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_DIV - 1);

    logic [DIV_W-1:0] div_reg;
    logic [DIV_W-1:0] div_next;
    logic             bclk_reg;
    logic             bclk_next;
    logic             wrap;

    always_comb begin
        wrap      = run && (div_reg == DIV_LAST);
        div_next  = div_reg;
        bclk_next = bclk_reg;
        if (!run) begin
            div_next  = '0;
            bclk_next = 1'b0;
        end else if (wrap) begin
            div_next  = '0;
            bclk_next = ~bclk_reg;
        end else begin
            div_next  = div_reg + DIV_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_reg  <= '0;
            bclk_reg <= 1'b0;
        end else begin
            div_reg  <= div_next;
            bclk_reg <= bclk_next;
        end
    end

    assign bclk     = bclk_reg;
    assign rise_stb = wrap & ~bclk_reg;
    assign fall_stb = wrap & bclk_reg;

endmodule

// File: rtl/codec_dac_serializer.sv
// codec_dac_serializer
// I2S-style serializer feeding a mono sample to both codec DAC slots.
//   clk         : system clock
//   reset_n     : asynchronous active-low reset
//   enable      : run request (level); sampled only at frame boundaries
//   sample_in   : 20-bit two's-complement sample from the data PIO
//   aud_bclk    : codec bit clock
//   aud_daclrck : word select, 0 = left slot, 1 = right slot
//   aud_dacdat  : serial data, MSB first with a one-bit I2S delay
//   sample_tick : one-clk pulse on the clk that captures sample_in
//   busy        : high while running
// All codec outputs change on the clk where aud_bclk falls, so the codec
// sees stable data on every rising bit-clock edge.
module codec_dac_serializer
    import codec_audio_pkg::*;
#(
    parameter int BCLK_DIV = 4
)
(
    input  logic                clk,
    input  logic                reset_n,
    input  logic                enable,
    input  logic [SAMPLE_W-1:0] sample_in,
    output logic                aud_bclk,
    output logic                aud_daclrck,
    output logic                aud_dacdat,
    output logic                sample_tick,
    output logic                busy
);

    localparam logic [CNT_W-1:0] FRAME_LAST = CNT_W'(FRAME_BITS - 1);

    codec_state_t        state_reg;
    codec_state_t        state_next;
    logic [CNT_W-1:0]    bit_cnt_reg;
    logic [CNT_W-1:0]    bit_cnt_next;
    logic [SAMPLE_W-1:0] shadow_reg;
    logic [SAMPLE_W-1:0] shadow_next;
    logic                lrck_reg;
    logic                lrck_next;
    logic                dat_reg;
    logic                dat_next;
    logic                tick_reg;
    logic                tick_next;

    logic                bclk_run;
    logic                bclk_fall;
    // Data only moves on falling bit-clock edges; the rise strobe has no user here.
    logic                bclk_rise_unused;

    // Slot image: position 0 is the I2S delay bit, 1..20 carry the shadow
    // MSB first, the rest of the slot is zero padding.
    logic [SLOT_W-1:0]   slot_bits;

    genvar gi;
    generate
        for (gi = 0; gi < SLOT_W; gi++) begin : g_slot
            if (gi >= 1 && gi <= SAMPLE_W) begin : g_data
                assign slot_bits[gi] = shadow_reg[SAMPLE_W - gi];
            end else begin : g_pad
                assign slot_bits[gi] = 1'b0;
            end
        end
    endgenerate

    assign bclk_run = (state_reg == RUN);

    codec_bclk_gen #(
        .BCLK_DIV (BCLK_DIV)
    ) u_bclk_gen (
        .clk      (clk),
        .reset_n  (reset_n),
        .run      (bclk_run),
        .bclk     (aud_bclk),
        .rise_stb (bclk_rise_unused),
        .fall_stb (bclk_fall)
    );

    always_comb begin
        state_next   = state_reg;
        bit_cnt_next = bit_cnt_reg;
        shadow_next  = shadow_reg;
        lrck_next    = lrck_reg;
        dat_next     = dat_reg;
        tick_next    = 1'b0;

        case (state_reg)
            IDLE: begin
                // Parked at the last bit so the first falling edge in RUN
                // wraps to 0 and loads the first sample.
                bit_cnt_next = FRAME_LAST;
                lrck_next    = 1'b0;
                dat_next     = 1'b0;
                if (enable) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (bclk_fall) begin
                    if (bit_cnt_reg == FRAME_LAST) begin
                        lrck_next = 1'b0;
                        dat_next  = 1'b0;
                        if (!enable) begin
                            state_next   = IDLE;
                            bit_cnt_next = FRAME_LAST;
                        end else begin
                            bit_cnt_next = '0;
                            shadow_next  = sample_in;
                            tick_next    = 1'b1;
                        end
                    end else begin
                        bit_cnt_next = bit_cnt_reg + CNT_W'(1);
                        lrck_next    = bit_cnt_next[CNT_W-1];
                        dat_next     = slot_bits[bit_cnt_next[CNT_W-2:0]];
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg   <= IDLE;
            bit_cnt_reg <= FRAME_LAST;
            shadow_reg  <= '0;
            lrck_reg    <= 1'b0;
            dat_reg     <= 1'b0;
            tick_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            bit_cnt_reg <= bit_cnt_next;
            shadow_reg  <= shadow_next;
            lrck_reg    <= lrck_next;
            dat_reg     <= dat_next;
            tick_reg    <= tick_next;
        end
    end

    assign aud_daclrck = lrck_reg;
    assign aud_dacdat  = dat_reg;
    assign sample_tick = tick_reg;
    assign busy        = (state_reg == RUN);

endmodule

// File: tb/tb_codec_dac_serializer.sv
// tb_codec_dac_serializer
// Directed plus random bench for codec_dac_serializer. One instance runs with
// BCLK_DIV=4 (framing, enable and reset behaviour, random frames checked by a
// scoreboard), a second with BCLK_DIV=1 (fastest bit clock).
module tb_codec_dac_serializer;

    logic        clk;
    logic        reset_n;

    logic        enable4;
    logic [19:0] sample4;
    logic        bclk4, lrck4, dat4, tick4, busy4;

    logic        enable1;
    logic [19:0] sample1;
    logic        bclk1, lrck1, dat1, tick1, busy1;

    int          checks   = 0;
    int          failures = 0;

    logic [19:0] exp_q[$];
    int          tick_cnt4    = 0;
    int          fall_cnt4    = 0;
    int          frames_done4 = 0;

    codec_dac_serializer #(.BCLK_DIV(4)) dut4 (
        .clk         (clk),
        .reset_n     (reset_n),
        .enable      (enable4),
        .sample_in   (sample4),
        .aud_bclk    (bclk4),
        .aud_daclrck (lrck4),
        .aud_dacdat  (dat4),
        .sample_tick (tick4),
        .busy        (busy4)
    );

    codec_dac_serializer #(.BCLK_DIV(1)) dut1 (
        .clk         (clk),
        .reset_n     (reset_n),
        .enable      (enable1),
        .sample_in   (sample1),
        .aud_bclk    (bclk1),
        .aud_daclrck (lrck1),
        .aud_dacdat  (dat1),
        .sample_tick (tick1),
        .busy        (busy1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Rebuild the sample word from slot positions 1..20 (MSB first).
    function automatic logic [19:0] slot_word(input logic [63:0] bits, input int base);
        logic [19:0] w;
        w = '0;
        for (int p = 1; p <= 20; p++) w[20-p] = bits[base+p];
        return w;
    endfunction

    // Delay bit plus the 11 padding positions of one slot.
    function automatic logic [11:0] slot_pad(input logic [63:0] bits, input int base);
        logic [11:0] v;
        v[0] = bits[base];
        for (int p = 21; p <= 31; p++) v[p-20] = bits[base+p];
        return v;
    endfunction

    task automatic check_frame(input string tag, input logic [63:0] fd, input logic [63:0] fl,
                               input logic [19:0] exp);
        chk({tag, "_left"},  64'(slot_word(fd, 0)),  64'(exp));
        chk({tag, "_right"}, 64'(slot_word(fd, 32)), 64'(exp));
        chk({tag, "_pad"},   64'({slot_pad(fd, 32), slot_pad(fd, 0)}), 64'(0));
        chk({tag, "_lrck"},  fl, 64'hFFFF_FFFF_0000_0000);
    endtask

    // Monitor for the BCLK_DIV=4 instance: captures data on every rising bit
    // clock, starting at each sample_tick, and scores completed frames.
    initial begin : mon4
        logic        prev;
        logic [63:0] fd;
        logic [63:0] fl;
        logic [19:0] exp;
        int          pos;
        bit          active;
        prev = 1'b0; fd = '0; fl = '0; pos = 0; active = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                prev   = 1'b0;
                active = 1'b0;
                pos    = 0;
            end else begin
                if (bclk4 && !prev && active) begin
                    fd[pos] = dat4;
                    fl[pos] = lrck4;
                    pos++;
                    if (pos == 64) begin
                        active = 1'b0;
                        frames_done4++;
                        chk("sb_has_entry", 64'(exp_q.size() != 0), 64'(1));
                        if (exp_q.size() != 0) begin
                            exp = exp_q.pop_front();
                            check_frame("frame", fd, fl, exp);
                        end
                    end
                end
                if (prev && !bclk4) fall_cnt4++;
                if (tick4) begin
                    chk("frame_complete_before_tick", 64'(active), 64'(0));
                    tick_cnt4++;
                    active = 1'b1;
                    pos    = 0;
                    fd     = '0;
                    fl     = '0;
                end
                prev = bclk4;
            end
        end
    end

    task automatic wait_tick4(input string tag);
        int start;
        int cyc;
        start = tick_cnt4;
        cyc   = 0;
        while (tick_cnt4 == start && cyc < 1500) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk({tag, "_tick_seen"}, 64'(tick_cnt4 != start), 64'(1));
    endtask

    task automatic wait_falls4(input int n);
        int target;
        int cyc;
        target = fall_cnt4 + n;
        cyc    = 0;
        while (fall_cnt4 < target && cyc < n * 16 + 50) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("falls_reached", 64'(fall_cnt4 >= target), 64'(1));
    endtask

    task automatic wait_idle4(input string tag);
        int cyc;
        cyc = 0;
        while (busy4 && cyc < 1500) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk({tag, "_idle"}, 64'(busy4), 64'(0));
    endtask

    // Called just after enable is high with the block idle: the next edge
    // enters RUN; bclk rises 4 clk later and falls (with the tick) at 8.
    task automatic check_start(input string tag);
        @(posedge clk); #1;
        chk({tag, "_busy"},   64'(busy4), 64'(1));
        chk({tag, "_bclk0"},  64'(bclk4), 64'(0));
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk); #1;
            if (k == 3) chk({tag, "_bclk_k3"}, 64'(bclk4), 64'(0));
            if (k == 4) chk({tag, "_bclk_k4"}, 64'(bclk4), 64'(1));
            if (k == 7) begin
                chk({tag, "_bclk_k7"}, 64'(bclk4), 64'(1));
                chk({tag, "_tick_k7"}, 64'(tick4), 64'(0));
            end
            if (k == 8) begin
                chk({tag, "_bclk_k8"}, 64'(bclk4), 64'(0));
                chk({tag, "_tick_k8"}, 64'(tick4), 64'(1));
                chk({tag, "_lrck_k8"}, 64'(lrck4), 64'(0));
            end
        end
    endtask

    initial begin : stim
        int          cyc;
        int          t0;
        int          f0;
        int          toggles;
        int          early;
        logic        prev;
        logic [63:0] fd;
        logic [63:0] fl;

        reset_n = 1'b0;
        enable4 = 1'b0; sample4 = '0;
        enable1 = 1'b0; sample1 = '0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_bclk", 64'(bclk4), 64'(0));
        chk("rst_lrck", 64'(lrck4), 64'(0));
        chk("rst_dat",  64'(dat4),  64'(0));
        chk("rst_tick", 64'(tick4), 64'(0));
        chk("rst_busy", 64'(busy4), 64'(0));
        @(posedge clk); #1;
        reset_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("idle_wait_busy", 64'(busy4), 64'(0));

        // First frame from idle with 20'hA5A5A
        sample4 = 20'hA5A5A;
        exp_q.push_back(sample4);
        enable4 = 1'b1;
        check_start("start");

        // Mid-frame sample change only shows up in the next frame
        wait_falls4(10);
        sample4 = 20'h80001;
        exp_q.push_back(sample4);
        wait_tick4("frame2");

        // Drop enable at bit_cnt=10: frame finishes, then idle with no tick
        wait_falls4(10);
        enable4 = 1'b0;
        wait_idle4("drop");
        chk("drop_frames_done", 64'(frames_done4), 64'(2));
        repeat (16) @(posedge clk);
        #1;
        chk("drop_tick_cnt", 64'(tick_cnt4), 64'(2));
        chk("drop_bclk", 64'(bclk4), 64'(0));
        chk("drop_lrck", 64'(lrck4), 64'(0));
        chk("drop_dat",  64'(dat4),  64'(0));
        chk("drop_busy", 64'(busy4), 64'(0));

        // Asynchronous reset at bit_cnt=40
        sample4 = 20'h12345;
        exp_q.push_back(sample4);
        enable4 = 1'b1;
        wait_tick4("pre_rst");
        wait_falls4(40);
        cyc = 0;
        while (!bclk4 && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("pre_rst_bclk", 64'(bclk4), 64'(1));
        chk("pre_rst_lrck", 64'(lrck4), 64'(1));
        #1;
        reset_n = 1'b0;
        #1;
        chk("async_rst_bclk", 64'(bclk4), 64'(0));
        chk("async_rst_lrck", 64'(lrck4), 64'(0));
        chk("async_rst_dat",  64'(dat4),  64'(0));
        chk("async_rst_tick", 64'(tick4), 64'(0));
        chk("async_rst_busy", 64'(busy4), 64'(0));
        exp_q.delete();
        repeat (3) @(posedge clk);
        #1;
        t0 = tick_cnt4;
        f0 = frames_done4;
        sample4 = 20'hA5A5A;
        exp_q.push_back(sample4);
        reset_n = 1'b1;
        check_start("restart");

        // 100 random frames, each sample driven mid-frame
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #1;
            sample4 = 20'($urandom);
            exp_q.push_back(sample4);
            wait_tick4("rand");
        end
        enable4 = 1'b0;
        wait_idle4("rand_end");
        chk("rand_ticks",  64'(tick_cnt4 - t0),    64'(101));
        chk("rand_frames", 64'(frames_done4 - f0), 64'(101));
        chk("sb_drained",  64'(exp_q.size()),      64'(0));

        // BCLK_DIV=1: bclk toggles every clk, frame spans 128 clk
        @(posedge clk); #1;
        sample1 = 20'hFFFFF;
        enable1 = 1'b1;
        cyc = 0;
        while (!tick1 && cyc < 50) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("d1_first_tick", 64'(tick1), 64'(1));
        prev = bclk1; toggles = 0; early = 0; fd = '0; fl = '0;
        for (int k = 1; k <= 128; k++) begin
            @(posedge clk); #1;
            if (bclk1 != prev) toggles++;
            if (bclk1 && !prev) begin
                fd[(k-1)/2] = dat1;
                fl[(k-1)/2] = lrck1;
            end
            if (k < 128 && tick1) early++;
            prev = bclk1;
        end
        chk("d1_tick_at_128", 64'(tick1),   64'(1));
        chk("d1_toggles",     64'(toggles), 64'(128));
        chk("d1_early_ticks", 64'(early),   64'(0));
        check_frame("d1_frame", fd, fl, 20'hFFFFF);
        enable1 = 1'b0;
        repeat (4) @(posedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
